display_scan_ctrl: RTL

//  Time-multiplexed scan controller for the 8-digit seven-segment display.

---
 rtl/display_scan_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Optional per-slot blanking is enabled by defining SCAN_BLANK_EN.
module display_scan_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iDigits,
  input  logic [7:0]  iMask,
  input  logic        iLoad,
  output logic [3:0]  oData,
  output logic [2:0]  oSel,
  output logic        oEna,
  output logic        oFrame,
  output logic        oPending
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned SW = 3;

  // Reject parameter sets the counter and blanking window cannot represent.
  if (TICK_DIV < 2 || BLANK_CYC >= TICK_DIV) begin : g_param_check
    $error("display_scan_ctrl: need TICK_DIV >= 2 and BLANK_CYC < TICK_DIV");
  end

  logic [PW-1:0] psc, psc_n;
  logic [SW-1:0] sel_n;
  logic [DW-1:0] shd_digits, shd_digits_n, pend_digits, pend_digits_n;
  logic [MW-1:0] shd_mask, shd_mask_n, pend_mask, pend_mask_n;
  logic          pending_n;
  logic          slot_end, wrap, lit;
  logic [NW-1:0] data_n;
  logic          ena_n;

  // Next-state: prescaler/index stepping, pending capture and frame-boundary commit.
  always_comb begin
    slot_end      = (psc == PW'(TICK_DIV - 1));
    wrap          = slot_end && (oSel == SW'(7));
    psc_n         = slot_end ? '0 : psc + PW'(1);
    sel_n         = slot_end ? oSel + SW'(1) : oSel;
    shd_digits_n  = shd_digits;
    shd_mask_n    = shd_mask;
    pend_digits_n = pend_digits;
    pend_mask_n   = pend_mask;
    pending_n     = oPending;

    if (wrap) begin
      // A load in the wrap cycle itself bypasses and supersedes any pending copy.
      if (iLoad) begin
        shd_digits_n = iDigits;
        shd_mask_n   = iMask;
      end else if (oPending) begin
        shd_digits_n = pend_digits;
        shd_mask_n   = pend_mask;
      end
      pending_n = 1'b0;
    end else if (iLoad) begin
      pend_digits_n = iDigits;
      pend_mask_n   = iMask;
      pending_n     = 1'b1;
    end

`ifdef SCAN_BLANK_EN
    lit = (psc_n >= PW'(BLANK_CYC));
`else
    lit = 1'b1;
`endif

    data_n = shd_digits_n[{sel_n, 2'b00} +: NW];
    ena_n  = shd_mask_n[sel_n] && lit;
  end

  // State and registered outputs; oSel doubles as the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc         <= '0;
      oSel        <= '0;
      shd_digits  <= '0;
      shd_mask    <= '0;
      pend_digits <= '0;
      pend_mask   <= '0;
      oPending    <= 1'b0;
      oData       <= '0;
      oEna        <= 1'b0;
      oFrame      <= 1'b0;
    end else begin
      psc         <= psc_n;
      oSel        <= sel_n;
      shd_digits  <= shd_digits_n;
      shd_mask    <= shd_mask_n;
      pend_digits <= pend_digits_n;
      pend_mask   <= pend_mask_n;
      oPending    <= pending_n;
      oData       <= data_n;
      oEna        <= ena_n;
      oFrame      <= wrap;
    end
  end

endmodule
